coin_credit_accumulator: RTL
============================

// Module: coin_credit_accumulator
// PURPOSE
// - Upstream stage of the vending price comparator.
// - Accepts coin-insert pulses, accumulates the customer credit and drives it to the comparator's paid-amount input.
// - Consumes the price on vend completion and returns leftover credit as unit refund pulses.
// - Handles cancel and inactivity timeout.
// PARAMETERS
// CREDIT_W    4    width of credit/price buses; matches comparator operand width
// MAX_CREDIT  15   max credit held; must be <= 2**CREDIT_W-1
// TIMEOUT     200  idle cycles in COLLECT before auto-refund; >= 1
// TIMEOUT_W   8    idle counter width; 2**TIMEOUT_W > TIMEOUT
// PORTS
// clk          in   1         single clock, all logic on posedge
// rst          in   1         synchronous, active-high reset
// coin_valid   in   1         one-cycle coin-insert strobe
// coin_value   in   2         00=1 unit, 01=2, 10=5, 11=invalid/slug
// cancel       in   1         one-cycle customer cancel strobe
// vend_done    in   1         one-cycle strobe: dispenser delivered item
// price        in   CREDIT_W  item cost; same value feeds comparator num1
// credit       out  CREDIT_W  registered accumulated credit -> comparator num2
// coin_accept  out  1         pulse: coin accepted
// coin_reject  out  1         pulse: coin returned (invalid/overflow/busy)
// refund_pulse out  1         pulse: one credit unit returned to customer
// busy         out  1         high while in REFUND
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - state=IDLE; credit=0; idle counter=0.
//   - coin_accept, coin_reject, refund_pulse, busy all 0.
//   - Reset wins over every other input, including mid-REFUND: remaining credit is discarded, no further pulses.
// - All outputs are registered; every effect appears on the cycle after the causing strobe.
// - States:
//   - IDLE: credit==0.
//   - COLLECT: credit>0, accepting coins.
//   - REFUND: draining credit.
// - Per-cycle event priority: vend_done > cancel > timeout > coin_valid. A lower-priority coin in the same cycle is rejected.
// - Coin handling (IDLE/COLLECT):
//   - Decode coin_value to v.
//   - Accept if code!=11 and credit+v <= MAX_CREDIT. Compute the sum at CREDIT_W+1 bits so it cannot wrap.
//   - On accept: credit += v; coin_accept=1; idle counter cleared; IDLE -> COLLECT.
//   - Otherwise: coin_reject=1; credit unchanged.
// - vend_done in COLLECT:
//   - If credit >= price: credit -= price. Then go to REFUND if the result is > 0, else IDLE.
//   - If credit < price: ignored; no change.
//   - In IDLE or REFUND: ignored.
// - cancel in COLLECT -> REFUND. cancel in IDLE or REFUND: no effect.
// - Timeout:
//   - Idle counter increments each COLLECT cycle with no accepted coin.
//   - When it reaches TIMEOUT -> REFUND; counter cleared.
//   - Counter saturates and never wraps.
// - REFUND:
//   - busy=1.
//   - Each cycle: refund_pulse=1 and credit -= 1.
//   - Leave to IDLE on the cycle credit becomes 0, so exactly N pulses for credit N, on consecutive cycles.
//   - Coins arriving in REFUND are rejected.
// - Price change mid-COLLECT: only the price value at vend_done matters.
// - Never emits coin_accept and coin_reject in the same cycle.
// TESTING
// - Reset, then coins 01,10 -> credit 2 then 7; two coin_accept pulses; state COLLECT.
// - credit=7, price=6, vend_done -> credit 1, then 1 refund_pulse -> credit 0, IDLE, busy low.
// - credit=14, coin 01 -> coin_reject, credit stays 14. Coin 11 in IDLE -> coin_reject, credit 0.
// - credit=3, cancel + coin_valid same cycle -> coin_reject; 3 consecutive refund_pulse; credit 0.
// - credit=4, no activity TIMEOUT cycles -> REFUND, 4 pulses. vend_done with credit<price -> ignored.
// - Reset asserted after 2 pulses of a 5-unit refund -> next cycle credit 0, IDLE, no further pulses.

Source files
------------

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: collects coins into a credit register for the price
// comparator, settles a vend, and returns leftover credit as unit refund pulses.
module coin_credit_accumulator #(
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned TIMEOUT    = 200,
  parameter int unsigned TIMEOUT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                cancel,
  input  logic                vend_done,
  input  logic [CREDIT_W-1:0] price,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                refund_pulse,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REFUND  = 2'd2
  } state_t;

  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic [TIMEOUT_W-1:0]  r_idle;
  logic                  r_accept;
  logic                  r_reject;
  logic                  r_refund;
  logic                  r_busy;

  logic [CREDIT_W:0]     w_coin_v;
  logic [CREDIT_W:0]     w_sum;
  logic                  w_coin_ok;
  logic                  w_collect;
  logic                  w_vend;
  logic                  w_cancel;
  logic                  w_timeout;
  logic                  w_preempt;
  logic                  w_coin_take;
  logic                  w_coin_drop;
  logic [CREDIT_W-1:0]   w_after_vend;

  always_comb begin
    w_coin_v = '0;
    case (coin_value)
      2'b00:   w_coin_v = (CREDIT_W+1)'(1);
      2'b01:   w_coin_v = (CREDIT_W+1)'(2);
      2'b10:   w_coin_v = (CREDIT_W+1)'(5);
      default: w_coin_v = '0;
    endcase
  end

  // Sum is one bit wider than the credit so the overflow test cannot wrap.
  assign w_sum        = {1'b0, r_credit} + w_coin_v;
  assign w_coin_ok    = (coin_value != 2'b11) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_after_vend = r_credit - price;

  assign w_collect = (r_state == S_COLLECT);
  assign w_vend    = w_collect && vend_done && (r_credit >= price);
  assign w_cancel  = w_collect && cancel;
  // The idle cycle that would bring the counter to TIMEOUT starts the refund.
  assign w_timeout = w_collect && (r_idle >= TIMEOUT_W'(TIMEOUT - 1));
  assign w_preempt = w_vend || w_cancel || w_timeout;

  assign w_coin_take = coin_valid && !w_preempt && (r_state != S_REFUND) && w_coin_ok;
  assign w_coin_drop = coin_valid && !w_coin_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_idle   <= '0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_refund <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_accept <= w_coin_take;
      r_reject <= w_coin_drop;
      r_refund <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_idle <= '0;
          r_busy <= 1'b0;
          if (w_coin_take) begin
            r_credit <= w_sum[CREDIT_W-1:0];
            r_state  <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_vend) begin
            r_credit <= w_after_vend;
            r_idle   <= '0;
            if (w_after_vend != '0) begin
              r_state <= S_REFUND;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_cancel || w_timeout) begin
            r_state <= S_REFUND;
            r_busy  <= 1'b1;
            r_idle  <= '0;
          end else if (w_coin_take) begin
            r_credit <= w_sum[CREDIT_W-1:0];
            r_idle   <= '0;
          end else if (r_idle < TIMEOUT_W'(TIMEOUT)) begin
            r_idle <= r_idle + 1'b1;
          end
        end
        S_REFUND: begin
          r_idle <= '0;
          if (r_credit == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_refund <= 1'b1;
            r_credit <= r_credit - 1'b1;
            if (r_credit == CREDIT_W'(1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_credit <= '0;
          r_idle   <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign credit       = r_credit;
  assign coin_accept  = r_accept;
  assign coin_reject  = r_reject;
  assign refund_pulse = r_refund;
  assign busy         = r_busy;

endmodule
